// File: rtl/mips_multicycle_if.sv
// Unified instruction/data memory port of the multicycle MIPS core.
// The core drives the request side; the memory answers with mem_ready/mem_rdata.
interface mips_multicycle_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mips_multicycle.sv
// Multicycle MIPS core: FSM, datapath and a 32x32 register file sharing one
// unified instruction/data memory port.
module mips_multicycle #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    mips_multicycle_if.master mem,
    output logic              halted,
    output logic [31:0]       pc
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
        ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    state_t      state;
    state_t      next_state;
    state_t      illegal_target;
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_out;
    logic [31:0] mdr;
    logic [31:0] rf [32];
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_ext;
    logic [31:0] r_result;
    logic        funct_ok;
    logic        access;

    assign opcode  = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign funct   = ir[5:0];
    assign imm_ext = {{16{ir[15]}}, ir[15:0]};

    assign illegal_target = TRAP_ON_ILLEGAL ? HALT : FETCH;

    // Gating with rst drops an in-flight request the moment reset asserts,
    // and raises the first fetch request as soon as reset is released.
    assign access        = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    assign mem.mem_req   = rst && access;
    assign mem.mem_we    = rst && (state == MEMWR);
    assign mem.mem_addr  = (state == FETCH) ? pc : alu_out;
    assign mem.mem_wdata = b;
    assign halted        = (state == HALT);

    always_comb begin
        funct_ok = 1'b1;
        r_result = '0;
        case (funct)
            FN_ADD:  r_result = a + b;
            FN_SUB:  r_result = a - b;
            FN_AND:  r_result = a & b;
            FN_OR:   r_result = a | b;
            FN_SLT:  r_result = {31'b0, $signed(a) < $signed(b)};
            default: funct_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:  if (mem.mem_ready) next_state = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = funct_ok ? EXEC : illegal_target;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    default:      next_state = illegal_target;
                endcase
            end
            MEMADR: next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (mem.mem_ready) next_state = MEMWB;
            MEMWB:  next_state = FETCH;
            MEMWR:  if (mem.mem_ready) next_state = FETCH;
            EXEC:   next_state = ALUWB;
            ALUWB:  next_state = FETCH;
            ADDIEX: next_state = ADDIWB;
            ADDIWB: next_state = FETCH;
            BRANCH: next_state = FETCH;
            JUMP:   next_state = FETCH;
            HALT:   next_state = HALT;
            default: next_state = FETCH;
        endcase
    end

    // DECODE parks the branch target in alu_out; BRANCH is the only consumer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (mem.mem_ready) begin
                        ir <= mem.mem_rdata;
                        pc <= pc + 32'd4;
                    end
                end
                DECODE: begin
                    a       <= rf[rs];
                    b       <= rf[rt];
                    alu_out <= pc + {imm_ext[29:0], 2'b00};
                end
                MEMADR: alu_out <= a + imm_ext;
                MEMRD:  if (mem.mem_ready) mdr <= mem.mem_rdata;
                MEMWB:  if (rt != 5'd0) rf[rt] <= mdr;
                EXEC:   alu_out <= r_result;
                ALUWB:  if (rd != 5'd0) rf[rd] <= alu_out;
                ADDIEX: alu_out <= a + imm_ext;
                ADDIWB: if (rt != 5'd0) rf[rt] <= alu_out;
                BRANCH: if (a == b) pc <= alu_out;
                JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mips_multicycle.md
MIPS_MULTICYCLE -- requirements
Module: mips_multicycle

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter TRAP_ON_ILLEGAL, default 1: 1 = halt on an unsupported opcode or funct; 0 = treat it as a NOP.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 mem_req  output  1  memory access request, held high until accepted.
REQ-006 mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-007 mem_addr  output  32  byte address; valid while mem_req=1.
REQ-008 mem_wdata  output  32  store data; valid while mem_req=1 and mem_we=1.
REQ-009 mem_rdata  input  32  read data; valid in the cycle mem_ready=1.
REQ-010 mem_ready  input  1  access completes on a rising edge where mem_req=1 and mem_ready=1.
REQ-011 halted  output  1  core stopped on an illegal instruction; sticky until reset.
REQ-012 pc  output  32  current PC register, for debug.

Function
REQ-013 The block SHALL be a multicycle MIPS core using one unified instruction/data memory port, with the FSM, the datapath and a 32x32 register file all inside this module.
REQ-014 Supported instructions:
- R-type add/sub/and/or/slt (funct 20/22/24/25/2A hex)
- lw (23h), sw (2Bh), beq (04h), addi (08h), j (02h)
- add/sub/addi SHALL wrap modulo 2^32 and SHALL NOT trap on overflow.
REQ-015 FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT.
REQ-016 FETCH:
- drive mem_req=1, mem_we=0, mem_addr=PC.
- On completion: IR<=mem_rdata, PC<=PC+4, go to DECODE.
- Otherwise stay in FETCH with outputs unchanged.
REQ-017 DECODE:
- latch A=rf[rs] and B=rf[rt].
- precompute the branch target PC+(signext(imm)<<2) using the already incremented PC.
- dispatch: lw/sw->MEMADR, R->EXEC, addi->ADDIEX, beq->BRANCH, j->JUMP.
- illegal opcode/funct->HALT if TRAP_ON_ILLEGAL=1, else FETCH.
REQ-018 MEMADR SHALL compute ALUOut=A+signext(imm), then go to MEMRD (lw) or MEMWR (sw).
REQ-019 MEMRD SHALL drive a read at ALUOut and capture the data on completion, then go to MEMWB. MEMWB SHALL write rf[rt] and then go to FETCH.
REQ-020 MEMWR SHALL drive mem_we=1, mem_addr=ALUOut, mem_wdata=B, and go to FETCH on completion.
REQ-021 R-type path: EXEC->ALUWB, writing rf[rd]. addi path: ADDIEX->ADDIWB, writing rf[rt]. Both then go to FETCH.
REQ-022 BRANCH SHALL set PC<=target when A==B, leave PC unchanged otherwise, and go to FETCH.
REQ-023 JUMP SHALL set PC<={PC[31:28], IR[25:0], 2'b00} and go to FETCH.
REQ-024 Cycle counts with zero wait states:
- lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each wait cycle (mem_req=1, mem_ready=0) adds exactly 1 cycle.
REQ-025 mem_req SHALL be 1 only in FETCH, MEMRD and MEMWR.
REQ-026 mem_ready SHALL be ignored while mem_req=0.
REQ-027 Register $0:
- SHALL always read as 0.
- Writes to $0 SHALL be discarded.
- The write-back of one instruction SHALL be visible to the DECODE of the next instruction.
REQ-028 HALT:
- halted=1, mem_req=0.
- PC, registers and IR frozen.
- Only reset exits HALT.
REQ-029 Address wrap: PC+4 at 32'hFFFF_FFFC SHALL wrap to 0. Address alignment SHALL NOT be checked.

Reset
REQ-030 While rst=0, the block SHALL force asynchronously:
- state=FETCH, PC=RESET_PC
- mem_req=0, mem_we=0, halted=0
- IR, A, B and ALUOut=0
REQ-031 Register file contents SHALL be cleared to 0 on reset.
REQ-032 The first mem_req SHALL assert in the first rising edge cycle after rst deasserts.
REQ-033 A reset asserted during a pending access SHALL drop mem_req immediately and abandon the access, without any register or PC update.

Verification
REQ-034 Scenario: mem_ready tied to 1; program addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,8($0); lw $4,8($0). Required: mem[8]=12, $4=12, total 4+4+4+4+5=21 cycles from reset release.
REQ-035 Scenario: beq $1,$1,+2 at PC 0x10. Required: PC=0x1C after 3 cycles. The same test with unequal registers SHALL give PC=0x14.
REQ-036 Scenario: mem_ready held low for 3 cycles during FETCH and MEMRD of lw. Required: mem_addr and mem_req stable throughout, lw takes 11 cycles, correct data written.
REQ-037 Scenario: opcode 3Fh with TRAP_ON_ILLEGAL=1. Required: halted=1 after DECODE and no further mem_req. The same test with TRAP_ON_ILLEGAL=0 SHALL fetch the next instruction at PC+4.
REQ-038 Scenario: addi $0,$0,9 then add $1,$0,$0. Required: $1=0. Separately, addi $5,$0,-1 then add $6,$5,$5 SHALL give $6=32'hFFFF_FFFE with no trap.
REQ-039 Scenario: assert rst mid-MEMWR and mid-HALT. Required: outputs immediately return to their reset values, pc=RESET_PC, halted=0, and no write is issued.
